// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a neuron spike train back into numbers.
//   - ISI measurement between consecutive spike events (IDLE/MEASURE/TIMEOUT FSM)
//   - per-window spike count and Q4.16 current estimate, offered on valid/ready
// Optional macro SPIKE_EDGE_EN: count only 0->1 transitions of spike, one cycle
// later than the level-sensitive default.
module spike_rate_decoder #(
  parameter int                 WIN_LEN = 1024,
  parameter int                 ISI_W   = 16,
  parameter int                 RATE_W  = 8,
  parameter logic signed [19:0] GAIN    = 20'sh0_1000,
  parameter logic signed [19:0] OFFSET  = 20'sh0_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spike,
  output logic [ISI_W-1:0]  isi,
  output logic              isi_valid,
  output logic              silent,
  output logic [RATE_W-1:0] rate,
  output logic [19:0]       i_est,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int                WCW      = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [WCW-1:0]    WIN_LAST = WCW'(WIN_LEN - 1);
  localparam logic [ISI_W-1:0]  ISI_MAX  = '1;
  localparam logic [RATE_W-1:0] RATE_MAX = '1;
  localparam int                PW       = RATE_W + 20;

  // ---------------------------------------------------------------------------
  // Spike event qualification
  // ---------------------------------------------------------------------------
  logic ev;

`ifdef SPIKE_EDGE_EN
  logic spk_d, ev_q;

  // Rising-edge detect, registered so a held-high pulse yields one event.
  always_ff @(posedge clk) begin
    if (reset) begin
      spk_d <= 1'b0;
      ev_q  <= 1'b0;
    end else begin
      spk_d <= spike;
      ev_q  <= spike & ~spk_d;
    end
  end

  assign ev = ev_q;
`else
  assign ev = spike;
`endif

  // ---------------------------------------------------------------------------
  // ISI FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

  state_t           state, state_nx;
  logic [ISI_W-1:0] isi_cnt, isi_cnt_nx;
  logic             isi_ld;

  // State and interval counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      isi_cnt <= '0;
    end else begin
      state   <= state_nx;
      isi_cnt <= isi_cnt_nx;
    end
  end

  // Next state; a spike after silence restarts timing but has no prior edge to measure from.
  always_comb begin
    state_nx   = state;
    isi_cnt_nx = isi_cnt;
    isi_ld     = 1'b0;
    case (state)
      IDLE, TIMEOUT: begin
        if (ev) begin
          state_nx   = MEASURE;
          isi_cnt_nx = ISI_W'(1);
        end
      end
      MEASURE: begin
        if (ev) begin
          isi_ld     = 1'b1;
          isi_cnt_nx = ISI_W'(1);
        end else if (isi_cnt == ISI_MAX) begin
          state_nx = TIMEOUT;
        end else begin
          isi_cnt_nx = isi_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign silent = (state != MEASURE);

  // Latch the measured interval and strobe it for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= isi_ld;
      if (isi_ld) isi <= isi_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Rate window and current estimate
  // ---------------------------------------------------------------------------
  logic [WCW-1:0]    win_cnt;
  logic [RATE_W-1:0] spk_cnt, spk_fin;
  logic              term;
  logic signed [PW-1:0] prod;
  logic signed [PW:0]   sum;
  logic [19:0]          est;

  assign term = (win_cnt == WIN_LAST);

  // Count including this cycle's event so a terminal-cycle spike lands in the closing window.
  always_comb begin
    spk_fin = spk_cnt;
    if (ev && (spk_cnt != RATE_MAX)) spk_fin = spk_cnt + 1'b1;
  end

  // Full-width product plus offset, then clamp into signed 20 bits.
  always_comb begin
    prod = $signed({20'b0, spk_fin}) * $signed({{RATE_W{GAIN[19]}}, GAIN});
    sum  = $signed({prod[PW-1], prod}) + $signed({{(PW-19){OFFSET[19]}}, OFFSET});
    if ((&sum[PW:19]) || ~(|sum[PW:19])) est = sum[19:0];
    else if (sum[PW])                    est = 20'h8_0000;
    else                                 est = 20'h7_FFFF;
  end

  // Window counters, result register and output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt   <= '0;
      spk_cnt   <= '0;
      rate      <= '0;
      i_est     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      win_cnt <= term ? '0 : win_cnt + 1'b1;
      spk_cnt <= term ? '0 : spk_fin;
      if (term) begin
        rate      <= spk_fin;
        i_est     <= est;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default-parameter instance for rate/ISI
// decoding, small instance (16-cycle window, 8-bit ISI, large gain) for timeout,
// terminal-cycle, saturation, overrun and mid-window reset cases.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic reset, spike, out_ready;

  always #5 clk = ~clk;

  logic [15:0] isi;
  logic        isi_valid, silent, out_valid, overrun;
  logic [7:0]  rate;
  logic [19:0] i_est;

  logic [7:0]  isi_s;
  logic        isi_valid_s, silent_s, out_valid_s, overrun_s;
  logic [7:0]  rate_s;
  logic [19:0] i_est_s;

  spike_rate_decoder u_dut (
    .clk(clk), .reset(reset), .spike(spike),
    .isi(isi), .isi_valid(isi_valid), .silent(silent),
    .rate(rate), .i_est(i_est), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  spike_rate_decoder #(
    .WIN_LEN(16), .ISI_W(8), .RATE_W(8),
    .GAIN(20'sh7_0000), .OFFSET(20'sh0_0000)
  ) u_small (
    .clk(clk), .reset(reset), .spike(spike),
    .isi(isi_s), .isi_valid(isi_valid_s), .silent(silent_s),
    .rate(rate_s), .i_est(i_est_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .overrun(overrun_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive spike for one cycle; returns just after the next falling edge.
  task automatic tick(input logic s);
    spike = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spike = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int npulse, nbad, nsil, nrate;
    reset     = 1'b1;
    spike     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state.
    chk("rst_isi",       isi,       0);
    chk("rst_isi_valid", isi_valid, 0);
    chk("rst_silent",    silent,    1);
    chk("rst_rate",      rate,      0);
    chk("rst_i_est",     i_est,     0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun",   overrun,   0);

    // Spike every 64 cycles, default parameters, out_ready=1.
    npulse = 0; nbad = 0;
    for (int c = 0; c < 2048; c++) begin
      tick(c % 64 == 0);
      if (isi_valid) begin
        npulse++;
        if (isi != 16'd64) nbad++;
      end
      if (c == 0)    chk("p64_silent_after_first", silent, 0);
      if (c == 0)    chk("p64_no_isi_first",       isi_valid, 0);
      if (c == 63)   chk("p64_isi_valid_early",    isi_valid, 0);
      if (c == 64)   chk("p64_isi_valid",          isi_valid, 1);
      if (c == 64)   chk("p64_isi",                isi, 64);
      if (c == 1022) chk("p64_ov_before_end",      out_valid, 0);
      if (c == 1023) chk("p64_ov_w0",              out_valid, 1);
      if (c == 1023) chk("p64_rate_w0",            rate, 16);
      if (c == 1023) chk("p64_iest_w0",            i_est, 20'h1_0000);
      if (c == 1024) chk("p64_ov_xfer",            out_valid, 0);
      if (c == 2047) chk("p64_rate_w1",            rate, 16);
      if (c == 2047) chk("p64_iest_w1",            i_est, 20'h1_0000);
      if (c == 2047) chk("p64_overrun",            overrun, 0);
    end
    chk("p64_isi_pulses", npulse, 31);
    chk("p64_isi_bad",    nbad,   0);

    // Silence for ISI_MAX+10 cycles on the small instance.
    do_reset();
    out_ready = 1'b1;
    nsil = 0; npulse = 0; nrate = 0;
    for (int c = 0; c < 265; c++) begin
      tick(1'b0);
      if (!silent_s) nsil++;
      if (isi_valid_s) npulse++;
      if (out_valid_s && (rate_s != 0 || i_est_s != 0)) nrate++;
      if (c == 15) chk("quiet_ov_w0",   out_valid_s, 1);
      if (c == 15) chk("quiet_rate_w0", rate_s, 0);
    end
    chk("quiet_silent_drops", nsil,   0);
    chk("quiet_isi_pulses",   npulse, 0);
    chk("quiet_nonzero_rate", nrate,  0);

    // Terminal-cycle spike and gain saturation.
    do_reset();
    for (int c = 0; c < 48; c++) begin
      tick(c == 3 || c == 15 || c == 20 || c == 35 || c == 40 || c == 45);
      if (c == 15) chk("term_isi_valid", isi_valid_s, 1);
      if (c == 15) chk("term_isi",       isi_s, 12);
      if (c == 15) chk("term_rate_w0",   rate_s, 2);
      if (c == 15) chk("term_iest_sat2", i_est_s, 20'h7_FFFF);
      if (c == 16) chk("term_ov_xfer",   out_valid_s, 0);
      if (c == 20) chk("term_isi2",      isi_s, 5);
      if (c == 31) chk("term_rate_w1",   rate_s, 1);
      if (c == 31) chk("term_iest_w1",   i_est_s, 20'h7_0000);
      if (c == 47) chk("sat_rate_w2",    rate_s, 3);
      if (c == 47) chk("sat_iest_w2",    i_est_s, 20'h7_FFFF);
    end

    // Overrun: out_ready low across two window ends, then one transfer.
    do_reset();
    for (int c = 0; c < 37; c++) begin
      out_ready = (c == 32);
      tick(c == 5 || c == 20 || c == 25);
      if (c == 15) chk("ovr_ov_w0",    out_valid_s, 1);
      if (c == 15) chk("ovr_rate_w0",  rate_s, 1);
      if (c == 15) chk("ovr_flag_w0",  overrun_s, 0);
      if (c == 31) chk("ovr_ov_w1",    out_valid_s, 1);
      if (c == 31) chk("ovr_rate_w1",  rate_s, 2);
      if (c == 31) chk("ovr_flag_w1",  overrun_s, 1);
      if (c == 32) chk("ovr_ov_xfer",  out_valid_s, 0);
      if (c == 36) chk("ovr_sticky",   overrun_s, 1);
      if (c == 36) chk("ovr_ov_stays", out_valid_s, 0);
    end

    // Timeout, post-timeout ISI, then reset mid-window.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 405; c++) begin
      tick(c == 0 || c == 300 || c == 400 || c == 403);
      if (c == 254) chk("to_silent_before", silent_s, 0);
      if (c == 255) chk("to_silent",        silent_s, 1);
      if (c == 299) chk("to_isi_held",      isi_s, 0);
      if (c == 300) chk("to_first_no_isi",  isi_valid_s, 0);
      if (c == 300) chk("to_measure",       silent_s, 0);
      if (c == 400) chk("to_isi_valid",     isi_valid_s, 1);
      if (c == 400) chk("to_isi_100",       isi_s, 100);
      if (c == 404) chk("to_ov_pre_rst",    out_valid_s, 1);
      if (c == 404) chk("to_ovr_pre_rst",   overrun_s, 1);
    end
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    chk("mr_isi",       isi_s,       0);
    chk("mr_isi_valid", isi_valid_s, 0);
    chk("mr_silent",    silent_s,    1);
    chk("mr_rate",      rate_s,      0);
    chk("mr_i_est",     i_est_s,     0);
    chk("mr_out_valid", out_valid_s, 0);
    chk("mr_overrun",   overrun_s,   0);
    for (int c = 0; c < 16; c++) begin
      tick(1'b0);
      if (c == 14) chk("mr_ov_before", out_valid_s, 0);
      if (c == 15) chk("mr_ov_w0",     out_valid_s, 1);
      if (c == 15) chk("mr_rate_w0",   rate_s, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receiver-side counterpart to the Izhikevich neuron core. It consumes the neuron's spike pulse train and decodes it back into numeric form:
- a per-spike inter-spike interval (ISI) measurement
- a per-window spike count
- an estimated stimulus current in the neuron's signed 20-bit Q4.16 format

Sits downstream of the neuron in the ECG processing chain. Results leave on a valid/ready handshake.

Parameters:
WIN_LEN, 1024, rate window length in clk cycles (>=2)
ISI_W, 16, ISI counter width; ISI_MAX = 2^ISI_W-1
RATE_W, 8, spike counter width; RATE_MAX = 2^RATE_W-1
GAIN, 20'sh0_1000, Q4.16 current per spike per window (1/16)
OFFSET, 20'sh0_0000, Q4.16 current added to every estimate

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
spike  in  1  spike pulse from neuron core
isi  out  ISI_W  last measured inter-spike interval, cycles
isi_valid  out  1  one-cycle strobe, isi updated
silent  out  1  high while no spike seen for ISI_MAX cycles, or none since reset
rate  out  RATE_W  spike count of last completed window
i_est  out  20  signed Q4.16 decoded current
out_valid  out  1  rate/i_est holding an unconsumed result
out_ready  in  1  downstream accepts result when high with out_valid
overrun  out  1  sticky: a window result replaced an unconsumed one

Behaviour:
- Clocking and reset:
  - One clock (clk). reset is synchronous and active-high.
  - While reset is high, next edge clears all state: isi=0, isi_valid=0, silent=1, rate=0, i_est=0, out_valid=0, overrun=0, window/ISI/spike counters=0, FSM=IDLE.
  - Reset mid-window discards the partial window with no output.
- Spike event: a cycle with spike=1; every such cycle counts (see Optional Feature).
- ISI FSM, states IDLE, MEASURE, TIMEOUT:
  - IDLE: silent=1. On spike event -> MEASURE, isi_cnt<=1, no isi_valid.
  - MEASURE: silent=0. Without spike, isi_cnt++.
    - On spike event: isi<=isi_cnt, isi_valid=1 next cycle for exactly 1 cycle, isi_cnt<=1.
    - This gives isi = t1-t0 for events at cycles t0 and t1.
    - If isi_cnt==ISI_MAX with no spike event -> TIMEOUT; isi_cnt holds.
  - TIMEOUT: silent=1, isi unchanged. On spike event -> MEASURE, isi_cnt<=1, no isi_valid (interval unknown).
- Rate window:
  - win_cnt is free-running 0..WIN_LEN-1 from reset release and wraps.
  - spk_cnt increments per spike event and saturates at RATE_MAX.
  - Terminal cycle (win_cnt==WIN_LEN-1):
    - A spike event in this cycle counts in the closing window.
    - At the edge: rate<=final count; i_est<=sat(OFFSET + final_count*GAIN); out_valid<=1; spk_cnt<=0.
    - Result is visible the cycle after the terminal cycle.
- Arithmetic:
  - Product is formed at full width (RATE_W+20 bits, signed), then OFFSET is added.
  - Result saturates to 20'sh7_FFFF / 20'sh8_0000. No wrap.
- Handshake:
  - rate/i_est stay stable while out_valid=1.
  - Transfer occurs on an edge where out_valid&&out_ready. out_valid then drops unless a new result lands on that same edge.
  - New result with out_valid=1 and no transfer that edge: overwrite, out_valid stays 1, overrun<=1.
  - Transfer and new result on the same edge: new result loads, out_valid stays 1, no overrun.
  - out_ready is ignored while out_valid=0.

Optional Feature:
SPIKE_EDGE_EN
- Defined: a spike event is a 0->1 transition of spike, using a one-flop history cleared by reset. A multi-cycle high pulse counts once, and ISI is measured between rising edges. This adds 1 cycle of latency to isi_valid and to window accounting.
- Undefined: every cycle with spike=1 is a spike event, as described above.

Test Plan:
- Reset, then spike low for ISI_MAX+10 cycles -> silent=1 throughout, isi_valid never pulses, each window gives rate=0, i_est=0x0_0000.
- Spike pulse every 64 cycles, defaults, out_ready=1 -> after first spike isi_valid pulses with isi=64; each full window gives rate=16, i_est=20'sh1_0000.
- Spike on the terminal window cycle -> counted in the closing window (rate N+1), next window starts at 0.
- out_ready=0 across two window ends -> second result overwrites the first, overrun=1 (sticky), out_valid held; out_ready=1 -> one transfer, out_valid drops.
- GAIN=20'sh7_0000, 3 spikes/window -> i_est saturates to 20'sh7_FFFF.
- Silence of ISI_MAX cycles, then spikes at t and t+100 -> TIMEOUT, first spike gives no isi_valid, second gives isi=100; reset asserted mid-window -> all outputs at reset values next cycle.
